// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and stall controller for the 5-stage MIPS core. It sits
// beside the ID stage and watches the destination registers in flight in EX,
// MEM and WB. It produces:
//   - operand forwarding selects for the ID stage,
//   - pipeline write enables (PC/IF-ID, ID/EX),
//   - a hold for the back end (EX/MEM, MEM/WB),
//   - per-stage flush lines,
//   - sequencing for the multi-cycle mult/div unit and for the one-cycle
//     exception redirect.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-low reset
//   id_valid                    ID holds a real instruction
//   id_rs, id_rt                ID source register numbers
//   id_use_rs, id_use_rt        ID instruction reads rs / rt
//   id_md_op                    0 none, 1 mult, 2 div, 3 reserved (treated as none)
//   id_reads_hilo               ID instruction is mfhi/mflo
//   {ex,mem,wb}_reg_wen         stage will write the register file
//   {ex,mem,wb}_reg_num         destination register of that stage
//   ex_mem_to_reg               EX instruction is a load
//   mem_ready                   data memory handshake (0 = access not complete)
//   except                      exception taken in WB
//   busA_select, busB_select    0 regfile, 1 exe_data, 2 mem_data, 3 wb_data
//   if_write                    PC and IF/ID register enable
//   id_write                    ID/EX register enable
//   pipe_hold                   freezes EX/MEM and MEM/WB
//   id_flush, ex_flush,
//   mem_flush                   insert a bubble into the next stage
//   exc_redirect                load the exception vector into the PC
//   md_busy                     mult/div in progress
//   md_done                     one-cycle pulse when HI/LO holds the result
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [1:0] id_md_op,
    input  logic       id_reads_hilo,
    input  logic       ex_reg_wen,
    input  logic       mem_reg_wen,
    input  logic       wb_reg_wen,
    input  logic [4:0] ex_reg_num,
    input  logic [4:0] mem_reg_num,
    input  logic [4:0] wb_reg_num,
    input  logic       ex_mem_to_reg,
    input  logic       mem_ready,
    input  logic       except,
    output logic [1:0] busA_select,
    output logic [1:0] busB_select,
    output logic       if_write,
    output logic       id_write,
    output logic       pipe_hold,
    output logic       id_flush,
    output logic       ex_flush,
    output logic       mem_flush,
    output logic       exc_redirect,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MDWAIT = 2'd1,
        EXC    = 2'd2
    } state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic lu_hazard;
    logic mh_hazard;
    logic md_issue;
    logic default_active;

    // Youngest producer wins: EX over MEM over WB. Register 0 is hard-wired
    // zero in the register file, so it is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       ex_wen,  input logic [4:0] ex_num,
        input logic       mem_wen, input logic [4:0] mem_num,
        input logic       wb_wen,  input logic [4:0] wb_num
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (ex_wen && (ex_num == src)) begin
                sel = 2'd1;
            end else if (mem_wen && (mem_num == src)) begin
                sel = 2'd2;
            end else if (wb_wen && (wb_num == src)) begin
                sel = 2'd3;
            end
        end
        return sel;
    endfunction

    assign busA_select = fwd_sel(id_rs, ex_reg_wen, ex_reg_num, mem_reg_wen,
                                 mem_reg_num, wb_reg_wen, wb_reg_num);
    assign busB_select = fwd_sel(id_rt, ex_reg_wen, ex_reg_num, mem_reg_wen,
                                 mem_reg_num, wb_reg_wen, wb_reg_num);

    // These three depend only on registered state so they are glitch-free
    // and never form a combinational path from the pipeline inputs.
    assign md_busy      = (state_q == MDWAIT);
    assign md_done      = (state_q == MDWAIT) && (cnt_q == 6'd1);
    assign exc_redirect = (state_q == EXC);

    assign md_issue = (id_md_op == 2'd1) || (id_md_op == 2'd2);

    // A load in EX cannot forward to ID this cycle: its data only exists
    // once it reaches MEM, so ID must wait one cycle.
    assign lu_hazard = id_valid && ex_mem_to_reg && ex_reg_wen && (ex_reg_num != 5'd0) &&
                       ((id_use_rs && (id_rs == ex_reg_num)) ||
                        (id_use_rt && (id_rt == ex_reg_num)));

    // HI/LO readers and new mult/div ops must wait for the unit to go idle.
    assign mh_hazard = id_valid && md_busy && (id_reads_hilo || md_issue);

    always_comb begin
        if_write       = 1'b1;
        id_write       = 1'b1;
        pipe_hold      = 1'b0;
        id_flush       = 1'b0;
        ex_flush       = 1'b0;
        mem_flush      = 1'b0;
        default_active = 1'b0;

        if (except) begin
            // Kill everything younger than WB; PC is held this cycle and
            // reloaded with the vector on the next.
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            if_write  = 1'b0;
        end else if (state_q == EXC) begin
            // The instruction fetched alongside the redirect is discarded.
            id_flush = 1'b1;
        end else if (!mem_ready) begin
            // Whole pipe freezes; no bubbles so nothing is lost.
            if_write  = 1'b0;
            id_write  = 1'b0;
            pipe_hold = 1'b1;
        end else if (lu_hazard || mh_hazard) begin
            // Hold IF/ID, let ID/EX load a bubble.
            if_write = 1'b0;
            id_flush = 1'b1;
        end else begin
            default_active = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (except) begin
            // An exception aborts any mult/div in flight.
            state_d = EXC;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (default_active && id_valid && md_issue) begin
                        state_d = MDWAIT;
                        cnt_d   = (id_md_op == 2'd1) ? MUL_LOAD : DIV_LOAD;
                    end
                end
                MDWAIT: begin
                    // The unit runs independently of memory stalls.
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = RUN;
                    end
                end
                EXC: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt;
    logic [1:0] id_md_op;
    logic       id_reads_hilo;
    logic       ex_reg_wen, mem_reg_wen, wb_reg_wen;
    logic [4:0] ex_reg_num, mem_reg_num, wb_reg_num;
    logic       ex_mem_to_reg;
    logic       mem_ready;
    logic       except;
    logic [1:0] busA_select, busB_select;
    logic       if_write, id_write, pipe_hold;
    logic       id_flush, ex_flush, mem_flush;
    logic       exc_redirect, md_busy, md_done;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_md_op(id_md_op), .id_reads_hilo(id_reads_hilo),
        .ex_reg_wen(ex_reg_wen), .mem_reg_wen(mem_reg_wen), .wb_reg_wen(wb_reg_wen),
        .ex_reg_num(ex_reg_num), .mem_reg_num(mem_reg_num), .wb_reg_num(wb_reg_num),
        .ex_mem_to_reg(ex_mem_to_reg), .mem_ready(mem_ready), .except(except),
        .busA_select(busA_select), .busB_select(busB_select),
        .if_write(if_write), .id_write(id_write), .pipe_hold(pipe_hold),
        .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .exc_redirect(exc_redirect), .md_busy(md_busy), .md_done(md_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left: remaining busy cycles of the mult/div unit (0 = idle).
    // m_exc : the redirect cycle following an exception is pending.
    int m_left = 0;
    bit m_exc  = 1'b0;

    function automatic int fsel(input logic [4:0] r);
        if (r == 0) return 0;
        if (ex_reg_wen && ex_reg_num == r) return 1;
        if (mem_reg_wen && mem_reg_num == r) return 2;
        if (wb_reg_wen && wb_reg_num == r) return 3;
        return 0;
    endfunction

    function automatic bit m_lu();
        return id_valid && ex_mem_to_reg && ex_reg_wen && ex_reg_num != 0 &&
               ((id_use_rs && id_rs == ex_reg_num) || (id_use_rt && id_rt == ex_reg_num));
    endfunction

    function automatic bit m_mdop();
        return id_md_op == 2'd1 || id_md_op == 2'd2;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_left <= 0;
            m_exc  <= 1'b0;
        end else if (except) begin
            m_left <= 0;
            m_exc  <= 1'b1;
        end else if (m_exc) begin
            m_exc <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (id_valid && m_mdop() && mem_ready && !m_lu()) begin
            m_left <= (id_md_op == 2'd1) ? MUL_CYCLES : DIV_CYCLES;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit e_ifw, e_idw, e_hold, e_idf, e_exf, e_memf, e_busy, mh;
            e_busy = (m_left > 0);
            mh     = id_valid && e_busy && (id_reads_hilo || m_mdop());
            e_ifw = 1; e_idw = 1; e_hold = 0; e_idf = 0; e_exf = 0; e_memf = 0;
            if (except) begin
                e_idf = 1; e_exf = 1; e_memf = 1; e_ifw = 0;
            end else if (m_exc) begin
                e_idf = 1;
            end else if (!mem_ready) begin
                e_ifw = 0; e_idw = 0; e_hold = 1;
            end else if (m_lu() || mh) begin
                e_ifw = 0; e_idf = 1;
            end
            chk("m_busA", busA_select, 8'(fsel(id_rs)));
            chk("m_busB", busB_select, 8'(fsel(id_rt)));
            chk("m_if_write", if_write, e_ifw);
            chk("m_id_write", id_write, e_idw);
            chk("m_pipe_hold", pipe_hold, e_hold);
            chk("m_id_flush", id_flush, e_idf);
            chk("m_ex_flush", ex_flush, e_exf);
            chk("m_mem_flush", mem_flush, e_memf);
            chk("m_md_busy", md_busy, e_busy);
            chk("m_md_done", md_done, 8'(m_left == 1));
            chk("m_exc_redirect", exc_redirect, m_exc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_md_op = 0; id_reads_hilo = 0;
        ex_reg_wen = 0; mem_reg_wen = 0; wb_reg_wen = 0;
        ex_reg_num = 0; mem_reg_num = 0; wb_reg_num = 0;
        ex_mem_to_reg = 0; mem_ready = 1; except = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_in_ex_r8();
        idle();
        id_valid = 1; id_rt = 8; id_use_rt = 1;
        ex_reg_wen = 1; ex_reg_num = 8; ex_mem_to_reg = 1;
    endtask

    task automatic load_in_mem_r8();
        idle();
        id_valid = 1; id_rt = 8; id_use_rt = 1;
        mem_reg_wen = 1; mem_reg_num = 8;
    endtask

    initial begin
        idle();
        rst = 0;
        tick();
        tick();
        rst = 1;
        cmp_en = 1;

        // reset state
        @(negedge clk);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_done", md_done, 0);
        chk("rst_exc_redirect", exc_redirect, 0);
        chk("rst_if_write", if_write, 1);
        chk("rst_id_write", id_write, 1);
        chk("rst_pipe_hold", pipe_hold, 0);
        chk("rst_busA", busA_select, 0);
        tick();

        // forwarding priority
        id_valid = 1; id_rs = 5; id_rt = 5; id_use_rs = 1; id_use_rt = 1;
        ex_reg_wen = 1; ex_reg_num = 5; mem_reg_wen = 1; mem_reg_num = 5;
        wb_reg_wen = 1; wb_reg_num = 5;
        @(negedge clk); chk("fwd_ex_A", busA_select, 1); chk("fwd_ex_B", busB_select, 1); tick();
        ex_reg_wen = 0;
        @(negedge clk); chk("fwd_mem_A", busA_select, 2); tick();
        mem_reg_wen = 0;
        @(negedge clk); chk("fwd_wb_A", busA_select, 3); tick();
        wb_reg_wen = 0;
        @(negedge clk); chk("fwd_none_A", busA_select, 0); tick();
        id_rs = 0; id_rt = 0;
        ex_reg_wen = 1; mem_reg_wen = 1; wb_reg_wen = 1;
        ex_reg_num = 0; mem_reg_num = 0; wb_reg_num = 0;
        @(negedge clk); chk("fwd_r0_A", busA_select, 0); chk("fwd_r0_B", busB_select, 0); tick();

        // load-use: one bubble, then forward from MEM
        load_in_ex_r8();
        @(negedge clk);
        chk("lu_if_write", if_write, 0); chk("lu_id_flush", id_flush, 1);
        chk("lu_id_write", id_write, 1);
        tick();
        load_in_mem_r8();
        @(negedge clk);
        chk("lu_next_busB", busB_select, 2); chk("lu_next_if_write", if_write, 1);
        chk("lu_next_id_flush", id_flush, 0);
        tick();

        // memory stall over a load-use hazard
        load_in_ex_r8();
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_pipe_hold", pipe_hold, 1); chk("mr_id_flush", id_flush, 0);
            chk("mr_if_write", if_write, 0); chk("mr_id_write", id_write, 0);
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        chk("mr_lu_id_flush", id_flush, 1); chk("mr_lu_if_write", if_write, 0);
        chk("mr_lu_pipe_hold", pipe_hold, 0);
        tick();
        load_in_mem_r8();
        @(negedge clk); chk("mr_after_if_write", if_write, 1); tick();

        // divide followed by a dependent mflo
        idle();
        id_valid = 1; id_md_op = 2;
        @(negedge clk); chk("div_issue_busy", md_busy, 0); chk("div_issue_if_write", if_write, 1);
        tick();
        id_md_op = 0; id_reads_hilo = 1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk("div_busy", md_busy, 1); chk("div_done", md_done, 8'(k == 32));
            chk("div_mflo_if_write", if_write, 0); chk("div_mflo_id_flush", id_flush, 1);
            tick();
        end
        @(negedge clk);
        chk("div_c33_busy", md_busy, 0); chk("div_c33_done", md_done, 0);
        chk("div_c33_if_write", if_write, 1); chk("div_c33_id_flush", id_flush, 0);
        tick();

        // mult aborted by an exception at cnt = 2
        idle();
        id_valid = 1; id_md_op = 1;
        tick();
        idle();
        tick(); // cnt 4
        tick(); // cnt 3
        except = 1; // cnt 2
        @(negedge clk);
        chk("exc_id_flush", id_flush, 1); chk("exc_ex_flush", ex_flush, 1);
        chk("exc_mem_flush", mem_flush, 1); chk("exc_if_write", if_write, 0);
        chk("exc_pipe_hold", pipe_hold, 0);
        tick();
        except = 0;
        @(negedge clk);
        chk("exc_redirect", exc_redirect, 1); chk("exc_md_busy", md_busy, 0);
        chk("exc_md_done", md_done, 0); chk("exc_redir_if_write", if_write, 1);
        chk("exc_redir_id_flush", id_flush, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("exc_after_done", md_done, 0); chk("exc_after_redirect", exc_redirect, 0);
            tick();
        end

        // back-to-back exceptions hold the FSM in EXC
        except = 1;
        tick();
        @(negedge clk); chk("exc2_redirect", exc_redirect, 1); chk("exc2_ex_flush", ex_flush, 1); tick();
        except = 0;
        @(negedge clk); chk("exc2_tail_redirect", exc_redirect, 1); tick();
        @(negedge clk); chk("exc2_end_redirect", exc_redirect, 0); tick();

        // reset mid-divide
        idle();
        id_valid = 1; id_md_op = 2;
        tick();
        idle();
        repeat (5) tick();
        rst = 0;
        @(negedge clk); chk("rstdiv_busy_before", md_busy, 1); tick();
        rst = 1;
        @(negedge clk);
        chk("rstdiv_busy", md_busy, 0); chk("rstdiv_done", md_done, 0);
        chk("rstdiv_if_write", if_write, 1);
        tick();
        repeat (4) tick();

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
